// File: rtl/capture_sequencer.sv
// capture_sequencer: synchronizes three raw event levels, detects their rising edges and runs a
// small IDLE/MEASURE/HOLD sequencer that issues one-cycle command pulses to a capture datapath.
// Each capture pulse pushes the counter value into a first-word-fall-through result FIFO.
//
// Optional feature: define CAPTURE_SEQ_TIMEOUT_EN to bound the MEASURE dwell to TIMEOUT_CYCLES.
// On expiry the block issues rst_capture, sets timeout_o and returns to IDLE. Without the macro,
// MEASURE persists indefinitely and timeout_o is tied low.
//
// Ports:
//   clk_i, rst_an_i           clock, asynchronous active-low reset
//   start_in_i, capture_in_i, rst_capture_in_i   raw asynchronous event levels
//   counter_i [31:0]          running counter from the capture datapath
//   *_rising_o                registered one-cycle command pulses (at most one per cycle)
//   data_o, valid_o, ready_i  FIFO head, head valid, consumer accept
//   level_o                   FIFO occupancy
//   state_o                   IDLE=0, MEASURE=1, HOLD=2
//   overflow_o, timeout_o     sticky flags; clear_i flushes the FIFO and clears both
module capture_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                          clk_i,
  input  logic                          rst_an_i,
  input  logic                          start_in_i,
  input  logic                          capture_in_i,
  input  logic                          rst_capture_in_i,
  input  logic [31:0]                   counter_i,
  output logic                          start_in_rising_o,
  output logic                          capture_in_rising_o,
  output logic                          rst_capture_in_rising_o,
  output logic [31:0]                   data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [1:0]                    state_o,
  output logic                          overflow_o,
  output logic                          timeout_o,
  input  logic                          clear_i
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMeasure = 2'd1,
    StHold    = 2'd2,
    StIllegal = 2'd3
  } state_e;

  // Bit order in the synchronizer vectors: {rst_capture, capture, start}.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  prev_q;
  logic [2:0]                  edge_det;

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {rst_capture_in_i, capture_in_i, start_in_i}};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Sequencer
  state_e state_q, state_d;
  logic   start_q, start_d;
  logic   cap_q, cap_d;
  logic   rstc_q, rstc_d;
  logic   timeout_set;

`ifdef CAPTURE_SEQ_TIMEOUT_EN
  logic [15:0] tcnt_q, tcnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    cap_d       = 1'b0;
    rstc_d      = 1'b0;
    timeout_set = 1'b0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    // Counter is zero everywhere except while dwelling in MEASURE without a command.
    tcnt_d      = '0;
`endif
    if (state_q == StIllegal) begin
      state_d = StIdle;
    end else if (edge_det[2]) begin
      rstc_d  = 1'b1;
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (edge_det[0]) begin
            start_d = 1'b1;
            state_d = StMeasure;
          end
        end
        StMeasure: begin
          if (edge_det[1]) begin
            cap_d   = 1'b1;
            state_d = StHold;
          end else if (edge_det[0]) begin
            start_d = 1'b1;
          end else begin
`ifdef CAPTURE_SEQ_TIMEOUT_EN
            if (tcnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
              rstc_d      = 1'b1;
              timeout_set = 1'b1;
              state_d     = StIdle;
            end else begin
              tcnt_d = tcnt_q + 16'd1;
            end
`endif
          end
        end
        StHold: begin
          if (edge_det[0]) begin
            start_d = 1'b1;
            state_d = StMeasure;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      cap_q   <= 1'b0;
      rstc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cap_q   <= cap_d;
      rstc_q  <= rstc_d;
    end
  end

`ifdef CAPTURE_SEQ_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      if (clear_i) begin
        timeout_q <= 1'b0;
      end else if (timeout_set) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // Result FIFO. The push uses counter_i during the cycle the capture pulse is high.
  logic [FIFO_DEPTH-1:0][31:0] mem_q;
  logic [PtrW-1:0]             wr_q, rd_q;
  logic [LvlW-1:0]             level_q;
  logic                        overflow_q;
  logic                        push, pop, full, push_ok;

  assign full    = (level_q == LvlW'(FIFO_DEPTH));
  assign push    = cap_q;
  assign pop     = valid_o && ready_i;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      mem_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_q <= rd_q + PtrW'(1);
      end
      if (push_ok) begin
        mem_q[wr_q] <= counter_i;
        wr_q        <= wr_q + PtrW'(1);
      end
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (push_ok && !pop) begin
        level_q <= level_q + LvlW'(1);
      end else if (!push_ok && pop) begin
        level_q <= level_q - LvlW'(1);
      end
    end
  end

  assign valid_o                 = (level_q != '0);
  assign data_o                  = valid_o ? mem_q[rd_q] : '0;
  assign level_o                 = level_q;
  assign overflow_o              = overflow_q;
  assign state_o                 = state_q;
  assign start_in_rising_o       = start_q;
  assign capture_in_rising_o     = cap_q;
  assign rst_capture_in_rising_o = rstc_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: directed scenarios plus randomized stimulus, all
// compared every cycle against a behavioural model (delay-line edge timing, queue FIFO).
module tb_capture_sequencer;
  localparam int unsigned Sync  = 2;
  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 8;

  logic        clk_i = 1'b0;
  logic        rst_an_i = 1'b0;
  logic        start_in_i = 1'b0, capture_in_i = 1'b0, rst_capture_in_i = 1'b0;
  logic [31:0] counter_i = 32'h10;
  logic        start_in_rising_o, capture_in_rising_o, rst_capture_in_rising_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [2:0]  level_o;
  logic [1:0]  state_o;
  logic        overflow_o, timeout_o;
  logic        clear_i = 1'b0;

  always #5 clk_i = ~clk_i;

  capture_sequencer #(
    .SYNC_STAGES   (Sync),
    .FIFO_DEPTH    (Depth),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk_i                  (clk_i),
    .rst_an_i               (rst_an_i),
    .start_in_i             (start_in_i),
    .capture_in_i           (capture_in_i),
    .rst_capture_in_i       (rst_capture_in_i),
    .counter_i              (counter_i),
    .start_in_rising_o      (start_in_rising_o),
    .capture_in_rising_o    (capture_in_rising_o),
    .rst_capture_in_rising_o(rst_capture_in_rising_o),
    .data_o                 (data_o),
    .valid_o                (valid_o),
    .ready_i                (ready_i),
    .level_o                (level_o),
    .state_o                (state_o),
    .overflow_o             (overflow_o),
    .timeout_o              (timeout_o),
    .clear_i                (clear_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // h*[j] holds the raw level sampled j+1 edges ago; an input's edge is acted on Sync edges after
  // its first high sample.
  bit          hs[8], hc[8], hr[8];
  int          m_state;
  bit          m_s, m_c, m_r, m_ov, m_to;
  int          m_cnt;
  logic [31:0] mq[$];

  function automatic void model_reset();
    for (int j = 0; j < 8; j++) begin
      hs[j] = 0; hc[j] = 0; hr[j] = 0;
    end
    m_state = 0; m_s = 0; m_c = 0; m_r = 0; m_ov = 0; m_to = 0; m_cnt = 0;
    mq.delete();
  endfunction

  function automatic void model_step();
    bit es, ec, er, push, pop, expire;
    es = hs[Sync-1] && !hs[Sync];
    ec = hc[Sync-1] && !hc[Sync];
    er = hr[Sync-1] && !hr[Sync];
    for (int j = 7; j > 0; j--) begin
      hs[j] = hs[j-1]; hc[j] = hc[j-1]; hr[j] = hr[j-1];
    end
    hs[0] = start_in_i; hc[0] = capture_in_i; hr[0] = rst_capture_in_i;

    push = m_c;
    pop  = (mq.size() != 0) && ready_i;
    if (clear_i) begin
      mq.delete(); m_ov = 0; m_to = 0;
    end else if (push && mq.size() == Depth && !pop) begin
      m_ov = 1;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(counter_i);
    end

    m_s = 0; m_c = 0; m_r = 0; expire = 0;
    if (er) begin
      m_r = 1; m_state = 0;
    end else begin
      case (m_state)
        0: if (es) begin m_s = 1; m_state = 1; m_cnt = 0; end
        1: begin
          if (ec) begin
            m_c = 1; m_state = 2;
          end else if (es) begin
            m_s = 1; m_cnt = 0;
          end else begin
`ifdef CAPTURE_SEQ_TIMEOUT_EN
            m_cnt++;
            if (m_cnt == Tmo) begin m_r = 1; m_state = 0; expire = 1; end
`endif
          end
        end
        default: if (es) begin m_s = 1; m_state = 1; m_cnt = 0; end
      endcase
    end
    if (expire && !clear_i) m_to = 1;
  endfunction

  task automatic compare();
    check("m_state", state_o, m_state);
    check("m_start_pulse", start_in_rising_o, m_s);
    check("m_cap_pulse", capture_in_rising_o, m_c);
    check("m_rstc_pulse", rst_capture_in_rising_o, m_r);
    check("m_level", level_o, mq.size());
    check("m_valid", valid_o, mq.size() != 0);
    check("m_data", data_o, (mq.size() != 0) ? mq[0] : 32'h0);
    check("m_overflow", overflow_o, m_ov);
    check("m_timeout", timeout_o, m_to);
  endtask

  always @(negedge rst_an_i) model_reset();

  always @(posedge clk_i) begin
    if (!rst_an_i) model_reset();
    else model_step();
    #1;
    compare();
  end

  // ---------------- stimulus ----------------
  bit rnd = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_i);
      counter_i = rnd ? $urandom : counter_i + 32'd1;
    end
  endtask

  // One start/capture sequence ending in HOLD; returns the value pushed.
  task automatic run_seq(input bit ready_at_push, output logic [31:0] val);
    start_in_i = 1; tick(4);
    start_in_i = 0; capture_in_i = 1; tick(3);
    check("seq_cap_pulse", capture_in_rising_o, 1);
    val = counter_i;
    if (ready_at_push) ready_i = 1;
    tick(1);
    ready_i = 0; capture_in_i = 0; tick(2);
  endtask

  task automatic do_clear();
    clear_i = 1; tick(1); clear_i = 0;
  endtask

  logic [31:0] vals[5];
  logic [31:0] cap_val;

  initial begin
    tick(3);
    check("rst_state", state_o, 0);
    check("rst_level", level_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    rst_an_i = 1; tick(2);

    // First start and capture
    start_in_i = 1; tick(2);
    check("a_no_early_pulse", start_in_rising_o, 0);
    tick(1);
    check("a_start_pulse", start_in_rising_o, 1);
    check("a_state_measure", state_o, 1);
    tick(1);
    check("a_start_one_wide", start_in_rising_o, 0);
    tick(16);
    capture_in_i = 1; tick(3);
    check("a_cap_pulse", capture_in_rising_o, 1);
    check("a_state_hold", state_o, 2);
    cap_val = counter_i; tick(1);
    check("a_level", level_o, 1);
    check("a_data", data_o, cap_val);
    check("a_data_ramp", data_o, 32'h10 + 32'd28);
    start_in_i = 0; capture_in_i = 0;
    do_clear(); tick(1);
    check("a_cleared", level_o, 0);

    // Five captures into a 4-deep FIFO with no consumer
    for (int i = 0; i < 5; i++) run_seq(0, vals[i]);
    check("b_level_full", level_o, 4);
    check("b_overflow", overflow_o, 1);
    check("b_head", data_o, vals[0]);
    do_clear(); tick(1);
    check("b_clear_level", level_o, 0);
    check("b_clear_ovf", overflow_o, 0);

    // Push with simultaneous pop while full
    for (int i = 0; i < 4; i++) run_seq(0, vals[i]);
    run_seq(1, vals[4]);
    check("c_level", level_o, 4);
    check("c_no_ovf", overflow_o, 0);
    check("c_head", data_o, vals[1]);
    ready_i = 1; tick(3); ready_i = 0;
    check("c_tail", data_o, vals[4]);
    check("c_tail_level", level_o, 1);
    do_clear(); tick(1);

    // Coincident edges in MEASURE
    start_in_i = 1; tick(4); start_in_i = 0; tick(2);
    check("d_measure", state_o, 1);
    start_in_i = 1; capture_in_i = 1; rst_capture_in_i = 1; tick(3);
    check("d_rstc_pulse", rst_capture_in_rising_o, 1);
    check("d_no_cap", capture_in_rising_o, 0);
    check("d_no_start", start_in_rising_o, 0);
    check("d_idle", state_o, 0);
    tick(1);
    check("d_no_push", level_o, 0);
    start_in_i = 0; capture_in_i = 0; rst_capture_in_i = 0; tick(2);

    // MEASURE dwell
    start_in_i = 1; tick(3);
    check("e_measure", state_o, 1);
    start_in_i = 0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    tick(Tmo - 1);
    check("e_pre_expiry", state_o, 1);
    tick(1);
    check("e_timeout_pulse", rst_capture_in_rising_o, 1);
    check("e_timeout_flag", timeout_o, 1);
    check("e_idle", state_o, 0);
`else
    tick(100);
    check("e_held", state_o, 1);
    check("e_no_timeout", timeout_o, 0);
`endif
    rst_capture_in_i = 1; tick(3);
    check("e_back_idle", state_o, 0);
    rst_capture_in_i = 0; tick(2);

    // Reset mid-MEASURE with two entries queued
    do_clear();
    run_seq(0, vals[0]);
    run_seq(0, vals[1]);
    start_in_i = 1; tick(3);
    check("f_level2", level_o, 2);
    check("f_measure", state_o, 1);
    #3 rst_an_i = 0;
    #1;
    check("f_state", state_o, 0);
    check("f_level", level_o, 0);
    check("f_valid", valid_o, 0);
    check("f_data", data_o, 0);
    check("f_start", start_in_rising_o, 0);
    check("f_ovf", overflow_o, 0);
    tick(2);
    rst_an_i = 1;
    tick(2);
    check("f_no_early_edge", start_in_rising_o, 0);
    tick(1);
    check("f_edge_after_rst", start_in_rising_o, 1);
    start_in_i = 0; tick(2);

    // Randomized traffic
    rnd = 1;
    for (int i = 0; i < 3000; i++) begin
      tick(1);
      if ($urandom_range(0, 7) == 0) start_in_i = ~start_in_i;
      if ($urandom_range(0, 7) == 0) capture_in_i = ~capture_in_i;
      if ($urandom_range(0, 19) == 0) rst_capture_in_i = ~rst_capture_in_i;
      ready_i = ($urandom_range(0, 3) == 0);
      clear_i = ($urandom_range(0, 63) == 0);
    end
    clear_i = 0; ready_i = 0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, 2, synchronizer depth for raw event inputs (legal 2..4).
REQ-002 Parameter FIFO_DEPTH, 4, capture-result FIFO entries (power of 2, 2..16).
REQ-003 Parameter TIMEOUT_CYCLES, 1000, maximum MEASURE dwell in clk_i cycles (legal 2..2^16-1).
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 rst_an_i  in  1  reset, asynchronous assert, active-low.
REQ-006 start_in_i / capture_in_i / rst_capture_in_i  in  1 each  raw asynchronous event levels.
REQ-007 counter_i  in  32  running counter value from the capture datapath.
REQ-008 start_in_rising_o / capture_in_rising_o / rst_capture_in_rising_o  out  1 each  one-cycle command pulses to the capture datapath.
REQ-009 data_o  out  32  FIFO head; valid_o  out  1  head valid; ready_i  in  1  consumer accepts head.
REQ-010 level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-011 state_o  out  2  IDLE=0, MEASURE=1, HOLD=2.
REQ-012 overflow_o / timeout_o  out  1 each  sticky flags; clear_i  in  1  synchronous flush and flag clear.

Function
REQ-013 Each raw input SHALL pass through SYNC_STAGES flops, then a rising-edge detector (current 1, previous 0).
REQ-014 Raw level first sampled high at edge N SHALL yield a command pulse high exactly during the cycle after edge N+SYNC_STAGES, one cycle wide; all command outputs registered.
REQ-015 At most one command pulse SHALL be asserted per cycle; priority rst_capture > capture > start.
REQ-016 A rst_capture edge in any state SHALL issue rst_capture_in_rising_o and enter IDLE.
REQ-017 IDLE: start edge -> start pulse, MEASURE; capture edge ignored (no pulse, no push).
REQ-018 MEASURE: capture edge -> capture pulse, push counter_i of that same cycle into FIFO, enter HOLD.
REQ-019 MEASURE: start edge (no higher-priority edge) -> start pulse, remain MEASURE, timeout counter restarts.
REQ-020 HOLD: start edge -> start pulse, MEASURE; capture edge ignored.
REQ-021 State encoding 3 is unreachable; if entered it SHALL return to IDLE next cycle with no pulse.
REQ-022 FIFO first-word-fall-through: valid_o = (level_o != 0); pop when valid_o && ready_i.
REQ-023 Push and pop in the same cycle SHALL both succeed, including when full; level unchanged.
REQ-024 Push when full without pop SHALL drop the data, set overflow_o; capture pulse still issued.
REQ-025 ready_i when empty SHALL have no effect; pointers wrap modulo FIFO_DEPTH.
REQ-026 clear_i SHALL empty the FIFO and clear overflow_o and timeout_o next edge; a push in the same cycle is discarded; FSM and command pulses unaffected.

Reset
REQ-027 rst_an_i low SHALL immediately force: state IDLE, all synchronizer/edge flops 0, command pulses 0, FIFO empty, level_o 0, valid_o 0, data_o 0, overflow_o 0, timeout_o 0, timeout counter 0.
REQ-028 Reset mid-operation SHALL discard FIFO contents; raw inputs already high at deassertion SHALL produce an edge after SYNC_STAGES+1 cycles (previous-value flop reset to 0).

Configuration
REQ-029 Macro CAPTURE_SEQ_TIMEOUT_EN defined: cycle counter in MEASURE; after TIMEOUT_CYCLES consecutive MEASURE cycles without leaving, issue rst_capture pulse, set timeout_o, enter IDLE; an edge in the expiry cycle takes precedence over timeout.
REQ-030 Macro undefined: no timeout counter, MEASURE persists indefinitely, timeout_o tied 0.

Verification
REQ-031 Reset, start_in_i high, counter_i=0x10 ramping, capture_in_i high 20 cycles later -> one start pulse 3 cycles after first sample, one capture pulse, data_o=counter_i at pulse cycle, level_o=1, state HOLD.
REQ-032 FIFO_DEPTH=4, five start/capture sequences, ready_i=0 -> level_o=4, overflow_o=1, data_o=first value; clear_i -> level_o=0, overflow_o=0.
REQ-033 Synchronizer edges of rst_capture, capture and start coincide in MEASURE -> only rst_capture pulse, state IDLE, no push.
REQ-034 CAPTURE_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, start then no capture -> rst_capture pulse after 8 MEASURE cycles, timeout_o=1, IDLE; undefined -> MEASURE held 100 cycles.
REQ-035 FIFO full, capture push with ready_i=1 same cycle -> level_o stays 4, overflow_o=0, new value at tail.
REQ-036 rst_an_i asserted mid-MEASURE with level_o=2 -> all outputs zero asynchronously, state IDLE.
